// File: rtl/jogada_input_tx_if.sv
// rtl/jogada_input_tx_if.sv - button input and debounced move-code bundle for jogada_input_tx
interface jogada_input_tx_if;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       jogada_valida;
    logic       ocupado;
    logic       acorde;

    modport master (
        output botoes,
        input  jogada,
        input  jogada_valida,
        input  ocupado,
        input  acorde
    );

    modport slave (
        input  botoes,
        output jogada,
        output jogada_valida,
        output ocupado,
        output acorde
    );
endinterface

// File: rtl/jogada_input_tx.sv
// rtl/jogada_input_tx.sv - synchronise, debounce and chord-filter 4 buttons into a one-hot move code
// Optional auto-repeat while held: define JOGADA_AUTO_REPEAT_EN.
module jogada_input_tx #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic              clock,
    input  logic              reset,
    jogada_input_tx_if.slave  bus
);

    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] FILTRANDO   = 3'd1;
    localparam logic [2:0] PRESSIONADO = 3'd2;
    localparam logic [2:0] REJEITADO   = 3'd3;
    localparam logic [2:0] SOLTANDO    = 3'd4;

    localparam logic [15:0] CNT_MAX  = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("jogada_input_tx: parameter out of range");
    end

    logic [3:0]  sync1_q, s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  state_q, state_d;
    logic [3:0]  jogada_q, jogada_d;
    logic        valida_q, valida_d;
    logic        acorde_q, acorde_d;
    logic        same, stable;
    logic [3:0]  code;

`ifdef JOGADA_AUTO_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);
    logic [31:0] rep_q, rep_d;
    logic        gap_q, gap_d;
    logic [3:0]  code_q, code_d;
    assign code = code_q;
`else
    assign code = jogada_q;
`endif

    // "same" looks one edge ahead: s_q will keep its value on this edge.
    assign same   = (sync1_q == s_q);
    assign stable = same && (cnt_q == CNT_LAST);
    assign cnt_d  = !same ? 16'd0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        jogada_d = jogada_q;
        valida_d = 1'b0;
        acorde_d = acorde_q;
`ifdef JOGADA_AUTO_REPEAT_EN
        rep_d    = '0;
        gap_d    = 1'b0;
        code_d   = code_q;
`endif
        case (state_q)
            OCIOSO: begin
                if (s_q != 4'd0) state_d = FILTRANDO;
            end
            FILTRANDO: begin
                if (s_q == 4'd0) begin
                    state_d = OCIOSO;
                end else if (stable) begin
                    if ($onehot(s_q)) begin
                        state_d  = PRESSIONADO;
                        jogada_d = s_q;
                        valida_d = 1'b1;
`ifdef JOGADA_AUTO_REPEAT_EN
                        code_d   = s_q;
`endif
                    end else begin
                        state_d  = REJEITADO;
                        acorde_d = 1'b1;
                    end
                end
            end
            PRESSIONADO: begin
                // A stable release consumes the only stable event, so go straight to idle.
                if (stable && s_q != code) begin
                    jogada_d = 4'd0;
                    state_d  = (s_q == 4'd0) ? OCIOSO : SOLTANDO;
                end
`ifdef JOGADA_AUTO_REPEAT_EN
                else if (gap_q) begin
                    jogada_d = code_q;
                    valida_d = 1'b1;
                end else if (rep_q == REP_LAST) begin
                    jogada_d = 4'd0;
                    gap_d    = 1'b1;
                end else begin
                    rep_d = rep_q + 32'd1;
                end
`endif
            end
            REJEITADO: begin
                if (stable && s_q == 4'd0) begin
                    state_d  = OCIOSO;
                    acorde_d = 1'b0;
                end
            end
            SOLTANDO: begin
                if (stable && s_q == 4'd0) state_d = OCIOSO;
            end
            default: begin
                state_d  = OCIOSO;
                jogada_d = 4'd0;
                acorde_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 4'd0;
            s_q      <= 4'd0;
            cnt_q    <= 16'd0;
            state_q  <= OCIOSO;
            jogada_q <= 4'd0;
            valida_q <= 1'b0;
            acorde_q <= 1'b0;
`ifdef JOGADA_AUTO_REPEAT_EN
            rep_q    <= '0;
            gap_q    <= 1'b0;
            code_q   <= 4'd0;
`endif
        end else begin
            sync1_q  <= bus.botoes;
            s_q      <= sync1_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            jogada_q <= jogada_d;
            valida_q <= valida_d;
            acorde_q <= acorde_d;
`ifdef JOGADA_AUTO_REPEAT_EN
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            code_q   <= code_d;
`endif
        end
    end

    assign bus.jogada        = jogada_q;
    assign bus.jogada_valida = valida_q;
    assign bus.ocupado       = (state_q != OCIOSO);
    assign bus.acorde        = acorde_q;

endmodule

// File: tb/tb_jogada_input_tx.sv
// tb/tb_jogada_input_tx.sv - directed vector bench for jogada_input_tx (DEBOUNCE=4, REPEAT=20)
module tb_jogada_input_tx;

    localparam int DEB = 4;
    localparam int REP = 20;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    jogada_input_tx_if bus ();

    jogada_input_tx #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] botoes;
        int         steps;
        logic [3:0] jog;
        logic       val;
        logic       ocu;
        logic       aco;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic prev_valid = 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            bus.botoes = vq[i].botoes;
            step(vq[i].steps);
            check($sformatf("%s[%0d].jogada", tag, i), 32'(bus.jogada), 32'(vq[i].jog));
            check($sformatf("%s[%0d].valida", tag, i), 32'(bus.jogada_valida), 32'(vq[i].val));
            check($sformatf("%s[%0d].ocupado", tag, i), 32'(bus.ocupado), 32'(vq[i].ocu));
            check($sformatf("%s[%0d].acorde", tag, i), 32'(bus.acorde), 32'(vq[i].aco));
        end
        vq.delete();
    endtask

    // Invariants on every cycle: one-hot-or-zero code, strobe never on consecutive edges.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            checks++;
            if (!$onehot0(bus.jogada)) begin
                errors++;
                $display("FAIL onehot0 actual=%b required=one-hot-or-zero", bus.jogada);
            end
            if (bus.jogada_valida) begin
                pulses++;
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valida_back_to_back actual=1 required=0");
                end
            end
            prev_valid = bus.jogada_valida;
        end
    end

    initial begin
        int p0;
        logic [3:0] ej;
        logic       ev;

        reset      = 1'b1;
        bus.botoes = 4'd0;
        step(2);
        check("reset.jogada", 32'(bus.jogada), 32'd0);
        check("reset.valida", 32'(bus.jogada_valida), 32'd0);
        check("reset.ocupado", 32'(bus.ocupado), 32'd0);
        check("reset.acorde", 32'(bus.acorde), 32'd0);
        reset = 1'b0;
        step(2);

        // Clean single press and release
        p0 = pulses;
        vq.push_back('{4'b0010, 5,  4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0010, 1,  4'b0010, 1'b1, 1'b1, 1'b0});
        vq.push_back('{4'b0010, 1,  4'b0010, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0010, 43, 4'b0010, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0000, 5,  4'b0010, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0000, 1,  4'b0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 10, 4'b0000, 1'b0, 1'b0, 1'b0});
        run_table("press");
        check("press.pulses", 32'(pulses - p0), 32'd1);

        // Bouncing button never accepted
        p0 = pulses;
        for (int k = 0; k < 8; k++) begin
            bus.botoes = 4'b0100;
            step(2);
            check("glitch.hi.jogada", 32'(bus.jogada), 32'd0);
            bus.botoes = 4'b0000;
            step(2);
            check("glitch.lo.jogada", 32'(bus.jogada), 32'd0);
        end
        step(10);
        check("glitch.ocupado", 32'(bus.ocupado), 32'd0);
        check("glitch.pulses", 32'(pulses - p0), 32'd0);

        // Chord rejected
        p0 = pulses;
        vq.push_back('{4'b0011, 5,  4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0011, 1,  4'b0000, 1'b0, 1'b1, 1'b1});
        vq.push_back('{4'b0011, 24, 4'b0000, 1'b0, 1'b1, 1'b1});
        vq.push_back('{4'b0000, 5,  4'b0000, 1'b0, 1'b1, 1'b1});
        vq.push_back('{4'b0000, 1,  4'b0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 4,  4'b0000, 1'b0, 1'b0, 1'b0});
        run_table("chord");
        check("chord.pulses", 32'(pulses - p0), 32'd0);

        // Second button added while pressed: code drops, no new strobe until release
        p0 = pulses;
        vq.push_back('{4'b1000, 6,  4'b1000, 1'b1, 1'b1, 1'b0});
        vq.push_back('{4'b1000, 10, 4'b1000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b1001, 5,  4'b1000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b1001, 1,  4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b1001, 20, 4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0000, 5,  4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0000, 1,  4'b0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 4,  4'b0000, 1'b0, 1'b0, 1'b0});
        run_table("add");
        check("add.pulses", 32'(pulses - p0), 32'd1);

        // Reset while a button is held
        vq.push_back('{4'b0001, 6, 4'b0001, 1'b1, 1'b1, 1'b0});
        vq.push_back('{4'b0001, 5, 4'b0001, 1'b0, 1'b1, 1'b0});
        run_table("prerst");
        reset = 1'b1;
        #1;
        check("midrst.jogada", 32'(bus.jogada), 32'd0);
        check("midrst.ocupado", 32'(bus.ocupado), 32'd0);
        check("midrst.valida", 32'(bus.jogada_valida), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        p0 = pulses;
        vq.push_back('{4'b0001, 5, 4'b0000, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b0001, 1, 4'b0001, 1'b1, 1'b1, 1'b0});
        vq.push_back('{4'b0000, 6, 4'b0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 4, 4'b0000, 1'b0, 1'b0, 1'b0});
        run_table("postrst");
        check("postrst.pulses", 32'(pulses - p0), 32'd1);

        // Long hold: one code per press, or periodic repeats when enabled
        p0 = pulses;
        for (int e = 1; e <= 90; e++) begin
            bus.botoes = (e <= 70) ? 4'b0001 : 4'b0000;
            step(1);
            ej = (e >= 6 && e < 76) ? 4'b0001 : 4'b0000;
            ev = (e == 6);
`ifdef JOGADA_AUTO_REPEAT_EN
            if (e == 26 || e == 47 || e == 68) ej = 4'b0000;
            if (e == 27 || e == 48 || e == 69) ev = 1'b1;
`endif
            check($sformatf("hold[%0d].jogada", e), 32'(bus.jogada), 32'(ej));
            check($sformatf("hold[%0d].valida", e), 32'(bus.jogada_valida), 32'(ev));
        end
        step(2);
`ifdef JOGADA_AUTO_REPEAT_EN
        check("hold.pulses", 32'(pulses - p0), 32'd4);
`else
        check("hold.pulses", 32'(pulses - p0), 32'd1);
`endif
        check("hold.ocupado", 32'(bus.ocupado), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
